// File: rtl/gray_pkg.sv
// gray_pkg
//   Shared definitions for binary/Gray conversion: mode encodings and
//   width-generic conversion functions. The functions work on a
//   GRAY_MAX_WIDTH container. Bits at and above `width` are forced to zero
//   before conversion, so bit width-1 behaves as the word MSB. The functions
//   are shared with the Gray-pointer FIFO work.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // All-ones mask covering the low `width` bits of the container.
  function automatic gray_word_t width_mask(input int unsigned width);
    gray_word_t m;
    if (width >= GRAY_MAX_WIDTH) begin
      m = '1;
    end else begin
      m = (gray_word_t'(1) << width) - gray_word_t'(1);
    end
    return m;
  endfunction

  // gray = b ^ (b >> 1); the zeroed bits above the word make its MSB pass through.
  function automatic gray_word_t bin2gray(input gray_word_t b, input int unsigned width);
    gray_word_t v;
    v = b & width_mask(width);
    return v ^ (v >> 1);
  endfunction

  // Running XOR from the MSB down: bin[i] = bin[i+1] ^ g[i].
  function automatic gray_word_t gray2bin(input gray_word_t g, input int unsigned width);
    gray_word_t v;
    gray_word_t b;
    v = g & width_mask(width);
    b = '0;
    b[GRAY_MAX_WIDTH-1] = v[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ v[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_comb.sv
// gray_conv_comb
//   Purely combinational WIDTH-bit binary/Gray converter. The direction is
//   chosen per word by `mode`.
// Ports:
//   data    input  [WIDTH-1:0]  word to convert
//   mode    input               MODE_B2G (0) or MODE_G2B (1)
//   result  output [WIDTH-1:0]  converted word, same width as data
module gray_conv_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    if (mode == MODE_G2B) begin
      result = WIDTH'(gray2bin(gray_word_t'(data), WIDTH));
    end else begin
      result = WIDTH'(bin2gray(gray_word_t'(data), WIDTH));
    end
  end

endmodule

// File: rtl/gray_code_converter_pipe.sv
// gray_code_converter_pipe
//   Two-stage pipelined binary/Gray converter with valid/ready on both sides.
//   S1 holds the raw word and its mode. S2 holds the converted word and drives
//   the output. Conversion sits between S1 and S2.
// Ports:
//   clk        input               rising-edge clock
//   rst        input               synchronous active-high reset
//   in_valid   input               input word present
//   in_ready   output              word can be accepted this cycle
//                                  (combinational from out_ready and rst)
//   in_data    input  [WIDTH-1:0]  word to convert
//   in_mode    input               0 = binary->Gray, 1 = Gray->binary
//   out_valid  output              converted word present
//   out_ready  input               downstream accepts this cycle
//   out_data   output [WIDTH-1:0]  converted word
//   out_mode   output              mode the word was converted with
module gray_code_converter_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
);

  logic             s1_v;
  logic [WIDTH-1:0] s1_data;
  logic             s1_mode;

  logic             s2_v;
  logic [WIDTH-1:0] s2_data;
  logic             s2_mode;

  logic [WIDTH-1:0] conv_data;
  logic             s1_load;
  logic             s2_load;

  gray_conv_comb #(
    .WIDTH (WIDTH)
  ) u_conv (
    .data   (s1_data),
    .mode   (s1_mode),
    .result (conv_data)
  );

  // An empty S2 pulls S1 forward regardless of out_ready, so bubbles collapse.
  assign s2_load  = s1_v && (!s2_v || out_ready);
  // Only refuse a word when both stages are full and the output is stalled.
  assign in_ready = !rst && (!s1_v || !s2_v || out_ready);
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_mode <= MODE_B2G;
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_mode <= MODE_B2G;
    end else begin
      if (s1_load) begin
        s1_v    <= 1'b1;
        s1_data <= in_data;
        s1_mode <= in_mode;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end

      if (s2_load) begin
        s2_v    <= 1'b1;
        s2_data <= conv_data;
        s2_mode <= s1_mode;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign out_valid = s2_v;
  assign out_data  = s2_data;
  assign out_mode  = s2_mode;

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// Testbench for gray_code_converter_pipe: three instances (WIDTH 8, 4, 16)
// sharing clock and reset. Expected words are queued when an input is
// accepted; per-instance monitors pop and compare on each output transfer.
module tb_gray_code_converter_pipe;

  logic clk;
  logic rst;

  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
  logic [7:0] a_in_data, a_out_data;
  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
  logic [3:0] b_in_data, b_out_data;
  logic        c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_out_mode;
  logic [15:0] c_in_data, c_out_data;

  logic [8:0]  qa[$];
  logic [4:0]  qb[$];
  logic [16:0] qc[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  int c_rcv    = 0;

  gray_code_converter_pipe #(.WIDTH(8)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_mode(a_out_mode)
  );

  gray_code_converter_pipe #(.WIDTH(4)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode)
  );

  gray_code_converter_pipe #(.WIDTH(16)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_mode(c_in_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_mode(c_out_mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Independent reference for the random run.
  function automatic logic [15:0] m_b2g(input logic [15:0] b);
    return b ^ {1'b0, b[15:1]};
  endfunction

  function automatic logic [15:0] m_g2b(input logic [15:0] g);
    logic [15:0] b;
    b = g;
    for (int s = 1; s < 16; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Monitors: one pop per output transfer.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) fail("a_unexpected_output");
      else check("a_word", {23'b0, a_out_mode, a_out_data}, {23'b0, qa.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) fail("b_unexpected_output");
      else check("b_word", {27'b0, b_out_mode, b_out_data}, {27'b0, qb.pop_front()});
    end
  end

  logic        c_hold = 1'b0;
  logic [16:0] c_prev = '0;
  always @(negedge clk) begin
    if (c_hold) check("c_stall_stable", {14'b0, c_out_valid, c_out_mode, c_out_data}, {14'b0, 1'b1, c_prev});
    if (c_out_valid && c_out_ready) begin
      c_rcv++;
      if (qc.size() == 0) fail("c_unexpected_output");
      else check("c_word", {15'b0, c_out_mode, c_out_data}, {15'b0, qc.pop_front()});
    end
    c_hold = c_out_valid && !c_out_ready && !rst;
    c_prev = {c_out_mode, c_out_data};
  end

  // Present a word on A until accepted; queue the hand-computed result.
  task automatic send_a(input logic [7:0] d, input logic m, input logic [7:0] e);
    int  cyc;
    logic acc;
    cyc = 0;
    acc = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_mode  = m;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = a_in_ready;
      if (acc) qa.push_back({m, e});
      @(posedge clk);
      #1;
      cyc++;
    end
    a_in_valid = 1'b0;
    if (!acc) fail("a_accept_timeout");
  endtask

  task automatic send_b(input logic [3:0] d, input logic m, input logic [3:0] e);
    int  cyc;
    logic acc;
    cyc = 0;
    acc = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_mode  = m;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = b_in_ready;
      if (acc) qb.push_back({m, e});
      @(posedge clk);
      #1;
      cyc++;
    end
    b_in_valid = 1'b0;
    if (!acc) fail("b_accept_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ta_in  [7];
    logic       ta_mode[7];
    logic [7:0] ta_exp [7];
    logic [3:0] gray4  [16];
    int t0;
    int sent;
    int guard;
    logic acc;

    ta_in   = '{8'h3B, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h80, 8'hFF};
    ta_mode = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    ta_exp  = '{8'h2D, 8'h80, 8'hFF, 8'h00, 8'h00, 8'hC0, 8'hAA};
    gray4   = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_mode = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_mode = 0; b_out_ready = 1;
    c_in_valid = 0; c_in_data = '0; c_in_mode = 0; c_out_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", {31'b0, a_in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    check("rst_out_data", {24'b0, a_out_data}, 32'd0);
    check("rst_out_mode", {31'b0, a_out_mode}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, a_in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Latency: accept at edge N, visible after edge N+1
    send_a(8'h2D, 1'b0, 8'h3B);
    @(negedge clk);
    check("lat_not_yet", {31'b0, a_out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'b0, a_out_valid}, 32'd1);
    check("lat_data", {24'b0, a_out_data}, 32'h3B);
    @(posedge clk);
    #1;

    // Directed boundary words, back-to-back
    for (int i = 0; i < 7; i++) send_a(ta_in[i], ta_mode[i], ta_exp[i]);
    repeat (4) @(posedge clk);
    #1;
    check("a_drain", qa.size(), 32'd0);

    // Backpressure: 0x01, 0x02 accepted, third refused until release
    a_out_ready = 1'b0;
    send_a(8'h01, 1'b0, 8'h01);
    send_a(8'h02, 1'b0, 8'h03);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", {31'b0, a_in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, a_out_valid}, 32'd1);
      check("bp_out_hold", {24'b0, a_out_data}, 32'h01);
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    t0 = cyc_cnt;
    send_a(8'h03, 1'b0, 8'h02);
    check("bp_simul_accept", cyc_cnt - t0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("bp_drain", qa.size(), 32'd0);

    // Reset with both stages full
    a_out_ready = 1'b0;
    send_a(8'h10, 1'b0, 8'h18);
    send_a(8'h55, 1'b1, 8'h66);
    @(negedge clk);
    check("full_before_rst", {30'b0, a_out_valid, a_in_ready}, 32'b10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'b0, a_in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    @(negedge clk);
    check("midrst_out_valid", {31'b0, a_out_valid}, 32'd0);
    check("midrst_out_data", {24'b0, a_out_data}, 32'd0);
    check("midrst_in_ready_after", {31'b0, a_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_residue", {31'b0, a_out_valid}, 32'd0);

    // WIDTH=4 sweep, alternating modes, back-to-back
    t0 = cyc_cnt;
    for (int i = 0; i < 16; i++) begin
      send_b(4'(i), 1'b0, gray4[i]);
      send_b(gray4[i], 1'b1, 4'(i));
    end
    check("b_throughput", cyc_cnt - t0, 32'd32);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("b_one_per_cycle", qb.size(), 32'd0);

    // WIDTH=16 random valid/ready, 10k words
    sent  = 0;
    guard = 0;
    acc   = 1'b0;
    @(posedge clk);
    #1;
    while (sent < 10000 && guard < 60000) begin
      if (acc || !c_in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          c_in_valid = 1'b1;
          c_in_data  = 16'($urandom);
          c_in_mode  = 1'($urandom_range(0, 1));
        end else begin
          c_in_valid = 1'b0;
        end
      end
      c_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = c_in_valid && c_in_ready;
      if (acc) begin
        qc.push_back({c_in_mode, c_in_mode ? m_g2b(c_in_data) : m_b2g(c_in_data)});
        sent++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    if (sent < 10000) fail("c_stimulus_timeout");
    repeat (6) @(posedge clk);
    #1;
    check("c_drain", qc.size(), 32'd0);
    check("c_count", c_rcv, 32'd10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
